// File: rtl/tx_huge_pages_sched_if.sv
// Host huge-page bus and TLP read-request handshake between the TX huge-page
// scheduler (master) and its environment (slave: BAR2 page registers plus TLP generator).
interface tx_huge_pages_sched_if;
  logic [63:0] huge_page_addr_1;
  logic [63:0] huge_page_addr_2;
  logic [31:0] huge_page_qwords_1;
  logic [31:0] huge_page_qwords_2;
  logic        huge_page_status_1;
  logic        huge_page_status_2;
  logic        huge_page_free_1;
  logic        huge_page_free_2;
  logic        rd_req;
  logic [63:0] rd_addr;
  logic [8:0]  rd_qwords;
  logic        rd_ack;
  logic        rd_done;
  logic        busy;
  logic        sched_err;

  modport master (
    input  huge_page_addr_1, huge_page_addr_2,
    input  huge_page_qwords_1, huge_page_qwords_2,
    input  huge_page_status_1, huge_page_status_2,
    input  rd_ack, rd_done,
    output huge_page_free_1, huge_page_free_2,
    output rd_req, rd_addr, rd_qwords,
    output busy, sched_err
  );

  modport slave (
    output huge_page_addr_1, huge_page_addr_2,
    output huge_page_qwords_1, huge_page_qwords_2,
    output huge_page_status_1, huge_page_status_2,
    output rd_ack, rd_done,
    input  huge_page_free_1, huge_page_free_2,
    input  rd_req, rd_addr, rd_qwords,
    input  busy, sched_err
  );
endinterface

// File: rtl/tx_huge_pages_sched.sv
// Splits the two alternately served host huge pages into DMA read requests
// (max size, no 4KB crossing) under an outstanding-request limit.
//
// state    | meaning
// ST_IDLE  | wait for the current page's status (ignored one cycle after FREE)
// ST_CALC  | compute next chunk = min(remain, MAX_RD_QWORDS, room to 4KB boundary)
// ST_REQ   | present request while under the outstanding limit, hold until ack
// ST_DRAIN | all requests issued, wait for outstanding to reach zero
// ST_FREE  | pulse free for the current page, switch to the other page
module tx_huge_pages_sched #(
  parameter int MAX_RD_QWORDS   = 16,
  parameter int MAX_OUTSTANDING = 4
) (
  input logic                   trn_clk,
  input logic                   reset_n,
  tx_huge_pages_sched_if.master hp
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CALC,
    ST_REQ,
    ST_DRAIN,
    ST_FREE
  } state_t;

  localparam logic [9:0] MAX_QW10 = 10'(MAX_RD_QWORDS);
  localparam logic [8:0] MAX_QW9  = 9'(MAX_RD_QWORDS);
  localparam logic [3:0] MAX_OUT  = 4'(MAX_OUTSTANDING);

  state_t      state_q, state_d;
  logic        page2_q;
  logic        skip_q;
  logic [63:0] addr_q;
  logic [31:0] remain_q;
  logic [3:0]  outstanding_q, outstanding_d;
  logic [8:0]  chunk_q;
  logic        rd_req_q;
  logic        free1_q;
  logic        free2_q;
  logic        busy_q;
  logic        err_q;

  logic [63:0] sel_addr;
  logic [31:0] sel_qwords;
  logic        sel_status;
  logic        accept;
  logic [9:0]  room_qw;
  logic [8:0]  lim;
  logic [8:0]  chunk_calc;

  assign sel_addr   = page2_q ? hp.huge_page_addr_2   : hp.huge_page_addr_1;
  assign sel_qwords = page2_q ? hp.huge_page_qwords_2 : hp.huge_page_qwords_1;
  assign sel_status = page2_q ? hp.huge_page_status_2 : hp.huge_page_status_1;
  assign accept     = rd_req_q & hp.rd_ack;

  // Addresses are qword aligned, so the room left in the 4KB page is 1..512 qwords.
  assign room_qw    = 10'd512 - {1'b0, addr_q[11:3]};
  assign lim        = (room_qw < MAX_QW10) ? room_qw[8:0] : MAX_QW9;
  assign chunk_calc = (remain_q < {23'd0, lim}) ? remain_q[8:0] : lim;

  always_comb begin
    outstanding_d = outstanding_q;
    if (accept && !hp.rd_done) begin
      outstanding_d = outstanding_q + 4'd1;
    end else if (!accept && hp.rd_done && (outstanding_q != 4'd0)) begin
      outstanding_d = outstanding_q - 4'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (!skip_q && sel_status) begin
          state_d = (sel_qwords == 32'd0) ? ST_FREE : ST_CALC;
        end
      end
      ST_CALC: state_d = ST_REQ;
      ST_REQ: begin
        if (accept) begin
          state_d = (remain_q == {23'd0, chunk_q}) ? ST_DRAIN : ST_CALC;
        end
      end
      ST_DRAIN: begin
        if (outstanding_q == 4'd0) state_d = ST_FREE;
      end
      ST_FREE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge trn_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      page2_q       <= 1'b0;
      skip_q        <= 1'b0;
      addr_q        <= 64'd0;
      remain_q      <= 32'd0;
      outstanding_q <= 4'd0;
      chunk_q       <= 9'd0;
      rd_req_q      <= 1'b0;
      free1_q       <= 1'b0;
      free2_q       <= 1'b0;
      busy_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      outstanding_q <= outstanding_d;
      skip_q        <= (state_q == ST_FREE);
      if (hp.rd_done && (outstanding_q == 4'd0)) err_q <= 1'b1;

      case (state_q)
        ST_IDLE: begin
          if (state_d == ST_CALC) begin
            addr_q   <= sel_addr;
            remain_q <= sel_qwords;
          end
        end
        ST_CALC: chunk_q <= chunk_calc;
        ST_REQ: begin
          if (accept) begin
            addr_q   <= addr_q + {52'd0, chunk_q, 3'b000};
            remain_q <= remain_q - {23'd0, chunk_q};
          end
        end
        ST_FREE: page2_q <= ~page2_q;
        default: ;
      endcase

      // Outstanding only drops while a request is waiting, so once raised rd_req holds until ack.
      rd_req_q <= (state_d == ST_REQ) && (outstanding_d < MAX_OUT);
      free1_q  <= (state_d == ST_FREE) && !page2_q;
      free2_q  <= (state_d == ST_FREE) && page2_q;
      busy_q   <= (state_d != ST_IDLE);
    end
  end

  assign hp.rd_req           = rd_req_q;
  assign hp.rd_addr          = addr_q;
  assign hp.rd_qwords        = chunk_q;
  assign hp.huge_page_free_1 = free1_q;
  assign hp.huge_page_free_2 = free2_q;
  assign hp.busy             = busy_q;
  assign hp.sched_err        = err_q;

endmodule

// File: tb/tb_tx_huge_pages_sched.sv
// Directed bench for tx_huge_pages_sched: a transaction-level model of the
// expected request/free sequence, checked every cycle by one monitor process.
module tb_tx_huge_pages_sched;
  localparam int MAX_RD   = 16;
  localparam int MAX_OUT  = 4;
  localparam int DONE_LAT = 5;

  logic trn_clk = 1'b0;
  logic reset_n;
  always #5 trn_clk = ~trn_clk;

  tx_huge_pages_sched_if sif();

  tx_huge_pages_sched #(
    .MAX_RD_QWORDS  (MAX_RD),
    .MAX_OUTSTANDING(MAX_OUT)
  ) dut (
    .trn_clk(trn_clk),
    .reset_n(reset_n),
    .hp     (sif)
  );

  logic ack_en, done_en, inject;
  int   done_credit;
  assign sif.rd_ack = sif.rd_req & ack_en;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          acc_cnt = 0;
  int          free_cnt[3] = '{0, 0, 0};
  logic [63:0] exp_addr[$];
  int          exp_qw[$];
  int          exp_free[$];
  int          pend[$];
  int          model_out = 0;
  logic        exp_err   = 1'b0;
  int          cyc       = 0;

  logic        prev_req, prev_acc, prev_free;
  logic [63:0] prev_addr;
  logic [8:0]  prev_qw;
  logic        acc, give;
  int          pg;
  logic [63:0] ea;
  int          eq;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge trn_clk);
    #2;
  endtask

  // Expected request sequence for one page: chunks bounded by size and 4KB room.
  task automatic expect_page(input int page, input logic [63:0] a0, input int q0);
    logic [63:0] a;
    int q, c, room;
    a = a0;
    q = q0;
    while (q > 0) begin
      room = (4096 - int'(a[11:0])) / 8;
      c = q;
      if (c > MAX_RD) c = MAX_RD;
      if (c > room) c = room;
      exp_addr.push_back(a);
      exp_qw.push_back(c);
      a = a + 64'(c * 8);
      q = q - c;
    end
    exp_free.push_back(page);
  endtask

  task automatic wait_free(input int page, input int budget);
    int base, k;
    base = free_cnt[page];
    k = 0;
    while (free_cnt[page] == base && k < budget) begin
      tick(1);
      k++;
    end
    chk($sformatf("free_%0d_seen", page), 64'(free_cnt[page] != base), 64'd1);
  endtask

  // Monitor / responder: checks outputs at negedge and drives rd_done.
  initial begin
    sif.rd_done = 1'b0;
    prev_req = 0; prev_acc = 0; prev_free = 0; prev_addr = 0; prev_qw = 0;
    forever begin
      @(negedge trn_clk);
      cyc++;
      if (!reset_n) begin
        chk("reset_outputs", {57'd0, sif.rd_req, sif.busy, sif.sched_err, sif.huge_page_free_1,
                              sif.huge_page_free_2, |sif.rd_addr, |sif.rd_qwords}, 64'd0);
        exp_addr.delete(); exp_qw.delete(); exp_free.delete(); pend.delete();
        model_out = 0; exp_err = 0; prev_req = 0; prev_acc = 0; prev_free = 0;
        sif.rd_done = 1'b0;
        continue;
      end
      acc = sif.rd_req && sif.rd_ack;
      if (prev_req && !prev_acc) begin
        chk("req_held", 64'(sif.rd_req), 64'd1);
        chk("addr_held", sif.rd_addr, prev_addr);
        chk("qwords_held", 64'(sif.rd_qwords), 64'(prev_qw));
      end
      if (sif.rd_req) begin
        chk("req_under_limit", 64'(model_out < MAX_OUT), 64'd1);
        chk("busy_with_req", 64'(sif.busy), 64'd1);
      end
      if (acc) begin
        chk("ack_spacing", 64'(prev_acc), 64'd0);
        if (exp_addr.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_req: got addr 0x%0h qwords %0d, expected no request",
                   sif.rd_addr, sif.rd_qwords);
        end else begin
          ea = exp_addr.pop_front();
          eq = exp_qw.pop_front();
          chk("req_addr", sif.rd_addr, ea);
          chk("req_qwords", 64'(sif.rd_qwords), 64'(eq));
        end
        chk("no_4k_cross", 64'((int'(sif.rd_addr[11:0]) + int'(sif.rd_qwords) * 8) <= 4096), 64'd1);
        acc_cnt++;
        pend.push_back(cyc + DONE_LAT);
      end
      if (sif.huge_page_free_1 || sif.huge_page_free_2) begin
        pg = sif.huge_page_free_2 ? 2 : 1;
        chk("free_onehot", 64'(sif.huge_page_free_1 & sif.huge_page_free_2), 64'd0);
        chk("free_pulse_width", 64'(prev_free), 64'd0);
        chk("free_after_drain", 64'(model_out), 64'd0);
        if (exp_free.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_free: got free on page %0d, expected none", pg);
        end else begin
          chk("free_page", 64'(pg), 64'(exp_free.pop_front()));
        end
        free_cnt[pg]++;
      end
      chk("sched_err", 64'(sif.sched_err), 64'(exp_err));

      give = 1'b0;
      if (inject) begin
        give = 1'b1;
        inject = 1'b0;
      end else if (pend.size() > 0 && pend[0] <= cyc && (done_en || done_credit > 0)) begin
        give = 1'b1;
        void'(pend.pop_front());
        if (!done_en) done_credit--;
      end
      if (give && model_out == 0) exp_err = 1'b1;
      if (acc && !give) model_out++;
      else if (!acc && give && model_out > 0) model_out--;
      sif.rd_done = give;

      prev_req  = sif.rd_req;
      prev_acc  = acc;
      prev_addr = sif.rd_addr;
      prev_qw   = sif.rd_qwords;
      prev_free = sif.huge_page_free_1 | sif.huge_page_free_2;
    end
  end

  initial begin
    int base, fb;
    reset_n = 1'b0;
    ack_en = 1'b1; done_en = 1'b1; inject = 1'b0; done_credit = 0;
    sif.huge_page_addr_1 = 0; sif.huge_page_addr_2 = 0;
    sif.huge_page_qwords_1 = 0; sif.huge_page_qwords_2 = 0;
    sif.huge_page_status_1 = 0; sif.huge_page_status_2 = 0;
    tick(3);
    reset_n = 1'b1;
    tick(2);
    chk("idle_after_reset", {62'd0, sif.busy, sif.rd_req}, 64'd0);

    // Page 2 alone after reset must be ignored.
    sif.huge_page_addr_2 = 64'h4000; sif.huge_page_qwords_2 = 16; sif.huge_page_status_2 = 1;
    base = acc_cnt;
    tick(10);
    chk("page2_first_ignored", 64'(acc_cnt - base), 64'd0);
    chk("page2_first_not_busy", 64'(sif.busy), 64'd0);
    sif.huge_page_status_2 = 0;
    tick(1);

    // Page 1, 40 qwords at 0x1000.
    sif.huge_page_addr_1 = 64'h1000; sif.huge_page_qwords_1 = 40;
    expect_page(1, 64'h1000, 40);
    chk("model_split_count", 64'(exp_addr.size()), 64'd3);
    chk("model_third_addr", exp_addr[2], 64'h1100);
    chk("model_third_len", 64'(exp_qw[2]), 64'd8);
    sif.huge_page_status_1 = 1;
    tick(1);
    chk("lat_calc_busy", 64'(sif.busy), 64'd1);
    chk("lat_calc_noreq", 64'(sif.rd_req), 64'd0);
    tick(1);
    chk("lat_req", 64'(sif.rd_req), 64'd1);
    chk("first_addr", sif.rd_addr, 64'h1000);
    chk("first_qwords", 64'(sif.rd_qwords), 64'd16);
    wait_free(1, 200);
    base = acc_cnt;
    tick(8);
    chk("cur_page_2_after_free", 64'(acc_cnt - base) + 64'(sif.busy), 64'd0);
    sif.huge_page_status_1 = 0;
    tick(1);

    // Page 2 with zero qwords: immediate free.
    sif.huge_page_qwords_2 = 0;
    exp_free.push_back(2);
    sif.huge_page_status_2 = 1;
    tick(1);
    chk("zero_q_free2", 64'(sif.huge_page_free_2), 64'd1);
    chk("zero_q_busy", 64'(sif.busy), 64'd1);
    chk("zero_q_noreq", 64'(sif.rd_req), 64'd0);
    sif.huge_page_status_2 = 0;
    tick(3);

    // Page 1 straddling a 4KB boundary.
    sif.huge_page_addr_1 = 64'h0FF0; sif.huge_page_qwords_1 = 10;
    expect_page(1, 64'h0FF0, 10);
    sif.huge_page_status_1 = 1;
    tick(2);
    chk("cross_first_addr", sif.rd_addr, 64'h0FF0);
    chk("cross_first_qwords", 64'(sif.rd_qwords), 64'd2);
    tick(2);
    chk("cross_second_req", 64'(sif.rd_req), 64'd1);
    chk("cross_second_addr", sif.rd_addr, 64'h1000);
    chk("cross_second_qwords", 64'(sif.rd_qwords), 64'd8);
    wait_free(1, 200);
    sif.huge_page_status_1 = 0;
    tick(2);

    // Page 2 high address near a boundary, ack withheld at first.
    ack_en = 1'b0;
    sif.huge_page_addr_2 = 64'h8000_0000_0000_3FC0; sif.huge_page_qwords_2 = 24;
    expect_page(2, 64'h8000_0000_0000_3FC0, 24);
    sif.huge_page_status_2 = 1;
    tick(6);
    chk("held_unacked_req", 64'(sif.rd_req), 64'd1);
    chk("held_unacked_qwords", 64'(sif.rd_qwords), 64'd8);
    ack_en = 1'b1;
    wait_free(2, 200);
    sif.huge_page_status_2 = 0;
    tick(2);

    // Both pages ready: page 1 then page 2.
    sif.huge_page_addr_1 = 64'h2000; sif.huge_page_qwords_1 = 16;
    sif.huge_page_addr_2 = 64'h5000; sif.huge_page_qwords_2 = 16;
    expect_page(1, 64'h2000, 16);
    expect_page(2, 64'h5000, 16);
    sif.huge_page_status_1 = 1; sif.huge_page_status_2 = 1;
    wait_free(1, 200);
    sif.huge_page_status_1 = 0;
    wait_free(2, 200);
    sif.huge_page_status_2 = 0;
    tick(2);

    // rd_done with nothing outstanding.
    chk("err_clear_before", 64'(sif.sched_err), 64'd0);
    inject = 1'b1;
    tick(2);
    chk("err_set", 64'(sif.sched_err), 64'd1);
    tick(5);
    chk("err_sticky", 64'(sif.sched_err), 64'd1);

    // Outstanding limit with completions withheld.
    done_en = 1'b0;
    sif.huge_page_addr_1 = 64'h10000; sif.huge_page_qwords_1 = 160;
    expect_page(1, 64'h10000, 160);
    base = acc_cnt;
    sif.huge_page_status_1 = 1;
    tick(30);
    chk("limit_acks", 64'(acc_cnt - base), 64'd4);
    chk("limit_req_low", 64'(sif.rd_req), 64'd0);
    done_credit = 1;
    tick(1);
    chk("limit_release_req", 64'(sif.rd_req), 64'd1);
    chk("limit_release_addr", sif.rd_addr, 64'h10200);
    done_en = 1'b1;
    wait_free(1, 500);
    sif.huge_page_status_1 = 0;
    tick(2);

    // Swap back to page 1 via an empty page 2.
    sif.huge_page_qwords_2 = 0;
    exp_free.push_back(2);
    sif.huge_page_status_2 = 1;
    wait_free(2, 20);
    sif.huge_page_status_2 = 0;
    tick(2);

    // Reset while draining two outstanding requests.
    done_en = 1'b0;
    sif.huge_page_addr_1 = 64'h6000; sif.huge_page_qwords_1 = 32;
    expect_page(1, 64'h6000, 32);
    base = acc_cnt;
    fb = free_cnt[1];
    sif.huge_page_status_1 = 1;
    tick(12);
    chk("drain_acks", 64'(acc_cnt - base), 64'd2);
    chk("drain_busy", 64'(sif.busy), 64'd1);
    reset_n = 1'b0;
    #1;
    chk("async_reset_req", 64'(sif.rd_req), 64'd0);
    chk("async_reset_busy", 64'(sif.busy), 64'd0);
    chk("async_reset_addr", sif.rd_addr, 64'd0);
    chk("async_reset_err", 64'(sif.sched_err), 64'd0);
    tick(2);
    reset_n = 1'b1;
    expect_page(1, 64'h6000, 32);
    done_en = 1'b1;
    wait_free(1, 200);
    chk("single_free_after_reset", 64'(free_cnt[1] - fb), 64'd1);
    sif.huge_page_status_1 = 0;
    tick(3);

    chk("all_reqs_issued", 64'(exp_addr.size()), 64'd0);
    chk("all_frees_seen", 64'(exp_free.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
